// File: rtl/uart_cmd_rx_pkg.sv
// Shared types and constants for the UART command receiver: header nibble
// and the state encodings of the byte receiver and frame assembler.
package uart_cmd_rx_pkg;

    localparam logic [3:0] CMD_HDR = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    typedef enum logic {
        WAIT_CMD,
        WAIT_DATA
    } asm_state_t;

endpackage

// File: rtl/uart_cmd_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, baud/bit counters and byte FSM.
// Emits registered one-cycle byte_valid / frame_err pulses after the stop sample.
module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // Counter values at which a sample is taken: half a bit after START entry,
    // then one full bit per sample.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic             r_frame_err;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_state      <= IDLE;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= rx;
            r_sync2      <= r_sync1;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state   <= START;
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= '0;
                        if (w_rx_s) begin
                            r_byte_valid <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= BREAK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    // A held-low line reports one error only; wait for idle.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_frame_err;
    assign rx_busy    = (r_state == DATA) || (r_state == STOP);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command front-end: assembles header/data byte pairs into one-cycle
// register write strobes; drops bad headers, framing errors and stalled frames.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       wr_en,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       cmd_err,
    output logic       busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    // Loaded one short so that expiry lands TIMEOUT_CYC cycles after entry.
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    logic            w_byte_valid;
    logic [7:0]      w_byte_data;
    logic            w_frame_err;
    logic            w_rx_busy;
    asm_state_t      r_state;
    logic [3:0]      r_pend_addr;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_wr_en;
    logic [3:0]      r_wr_addr;
    logic [7:0]      r_wr_data;
    logic            r_cmd_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(w_byte_valid),
        .byte_data (w_byte_data),
        .frame_err (w_frame_err),
        .rx_busy   (w_rx_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT_CMD;
            r_pend_addr <= '0;
            r_to_cnt    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_wr_en   <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                WAIT_CMD: begin
                    if (w_byte_valid) begin
                        if (w_byte_data[7:4] == CMD_HDR) begin
                            r_pend_addr <= w_byte_data[3:0];
                            r_to_cnt    <= TO_LOAD;
                            r_state     <= WAIT_DATA;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                WAIT_DATA: begin
                    // A byte arriving on the expiry cycle still completes the write.
                    if (w_byte_valid) begin
                        r_wr_data <= w_byte_data;
                        r_wr_addr <= r_pend_addr;
                        r_wr_en   <= 1'b1;
                        r_state   <= WAIT_CMD;
                    end else if (w_frame_err) begin
                        r_state <= WAIT_CMD;
                    end else if (r_to_cnt == '0) begin
                        r_cmd_err <= 1'b1;
                        r_state   <= WAIT_CMD;
                    end else begin
                        r_to_cnt <= r_to_cnt - TO_W'(1);
                    end
                end
                default: r_state <= WAIT_CMD;
            endcase
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cmd_err   = r_cmd_err;
    assign frame_err = w_frame_err;
    assign busy      = w_rx_busy || (r_state == WAIT_DATA);

endmodule
